// File: rtl/freq_signal_generator_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | freq_signal_generator_pkg                                              |
// | Shared constants and FSM encoding for the frequency signal generator.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package freq_signal_generator_pkg;

    // Shared with the frequency counter so both sides agree on window length.
    localparam int UPDATE_PERIOD_DEFAULT = 1200;
    localparam int MAX_COUNT_DEFAULT     = 99;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_DIGIT_MAX = 9;
    localparam int COUNT_W       = 7;
    localparam int TARGET_W      = 8;

    typedef enum logic [0:0] {
        STATE_IDLE = 1'b0,
        STATE_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/freq_signal_generator_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | freq_signal_generator_if                                               |
// | Control/status bundle of the frequency signal generator.               |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface freq_signal_generator_if #(
    parameter int BITS = 12
);
    logic              enable;
    logic [7:0]        target;
    logic              target_load;
    logic [BITS-1:0]   period;
    logic              period_load;
    logic              signal;
    logic              window_start;
    logic              load_pending;
    logic [6:0]        active_count;

    modport master (
        output enable, target, target_load, period, period_load,
        input  signal, window_start, load_pending, active_count
    );

    modport slave (
        input  enable, target, target_load, period, period_load,
        output signal, window_start, load_pending, active_count
    );
endinterface
`default_nettype wire

// File: rtl/freq_signal_generator_target_decode.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | freq_signal_generator_target_decode                                    |
// | Decodes the requested target (BCD when FREQ_GEN_BCD_TARGET_EN is       |
// | defined, binary otherwise) and clamps it to MAX_COUNT and L>>1.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module freq_signal_generator_target_decode
    import freq_signal_generator_pkg::*;
#(
    parameter int BITS      = 12,
    parameter int MAX_COUNT = MAX_COUNT_DEFAULT
) (
    input  wire logic [TARGET_W-1:0] target,
    input  wire logic [BITS-1:0]     period,
    output logic      [COUNT_W-1:0]  active_count
);

    logic [COUNT_W-1:0] w_decoded;
    logic [COUNT_W-1:0] w_capped;
    logic [BITS:0]      w_half_len;

`ifdef FREQ_GEN_BCD_TARGET_EN
    logic [BCD_DIGIT_W-1:0] w_tens;
    logic [BCD_DIGIT_W-1:0] w_units;

    always_comb begin
        w_tens  = (target[7:4] > BCD_DIGIT_W'(BCD_DIGIT_MAX)) ? BCD_DIGIT_W'(BCD_DIGIT_MAX) : target[7:4];
        w_units = (target[3:0] > BCD_DIGIT_W'(BCD_DIGIT_MAX)) ? BCD_DIGIT_W'(BCD_DIGIT_MAX) : target[3:0];
        w_decoded = COUNT_W'(w_tens) * COUNT_W'(10) + COUNT_W'(w_units);
    end
`else
    logic unused_target_msb;

    assign unused_target_msb = target[7];
    assign w_decoded         = target[6:0];
`endif

    // L>>1 bound keeps 2*count <= L, so the accumulator toggles at most once per clock.
    always_comb begin
        w_half_len = ({1'b0, period} + (BITS+1)'(1)) >> 1;
        w_capped   = (w_decoded > COUNT_W'(MAX_COUNT)) ? COUNT_W'(MAX_COUNT) : w_decoded;
        if ({{(BITS-COUNT_W+1){1'b0}}, w_capped} > w_half_len) begin
            active_count = COUNT_W'(w_half_len);
        end else begin
            active_count = w_capped;
        end
    end

endmodule
`default_nettype wire

// File: rtl/freq_signal_generator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | freq_signal_generator                                                  |
// | Emits exactly N rising edges per window of update_period+1 clocks      |
// | using a Bresenham accumulator. Option: FREQ_GEN_BCD_TARGET_EN.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module freq_signal_generator
    import freq_signal_generator_pkg::*;
#(
    parameter int BITS          = 12,
    parameter int UPDATE_PERIOD = UPDATE_PERIOD_DEFAULT,
    parameter int MAX_COUNT     = MAX_COUNT_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              reset,
    freq_signal_generator_if.slave bus
);

    state_t                state_q,         state_d;
    logic [BITS-1:0]       win_cnt_q,       win_cnt_d;
    logic [BITS:0]         acc_q,           acc_d;
    logic                  signal_q,        signal_d;
    logic                  window_start_q,  window_start_d;
    logic                  load_pending_q,  load_pending_d;
    logic [COUNT_W-1:0]    active_count_q,  active_count_d;
    logic [BITS-1:0]       update_period_q, update_period_d;
    logic [TARGET_W-1:0]   pend_target_q,   pend_target_d;
    logic [BITS-1:0]       pend_period_q,   pend_period_d;

    logic [TARGET_W-1:0]   w_commit_target;
    logic [BITS-1:0]       w_commit_period;
    logic [COUNT_W-1:0]    w_decoded_count;
    logic [BITS:0]         w_period_len;
    logic [BITS:0]         w_sum;
    logic                  w_boundary;

    // A strobe on the boundary cycle itself must land in the window that starts next.
    assign w_commit_target = bus.target_load ? bus.target : pend_target_q;
    assign w_commit_period = bus.period_load ? bus.period : pend_period_q;

    freq_signal_generator_target_decode #(
        .BITS      (BITS),
        .MAX_COUNT (MAX_COUNT)
    ) u_target_decode (
        .target       (w_commit_target),
        .period       (w_commit_period),
        .active_count (w_decoded_count)
    );

    assign w_period_len = {1'b0, update_period_q} + (BITS+1)'(1);
    assign w_sum        = acc_q + {{(BITS-COUNT_W){1'b0}}, active_count_q, 1'b0};

    always_comb begin
        state_d         = state_q;
        win_cnt_d       = win_cnt_q;
        acc_d           = acc_q;
        signal_d        = signal_q;
        window_start_d  = 1'b0;
        active_count_d  = active_count_q;
        update_period_d = update_period_q;
        pend_target_d   = w_commit_target;
        pend_period_d   = w_commit_period;
        load_pending_d  = load_pending_q | bus.target_load | bus.period_load;
        w_boundary      = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                win_cnt_d = '0;
                acc_d     = '0;
                signal_d  = 1'b0;
                if (bus.enable) begin
                    state_d    = STATE_RUN;
                    w_boundary = 1'b1;
                end
            end
            STATE_RUN: begin
                if (!bus.enable) begin
                    state_d   = STATE_IDLE;
                    win_cnt_d = '0;
                    acc_d     = '0;
                    signal_d  = 1'b0;
                end else if (win_cnt_q == update_period_q) begin
                    w_boundary = 1'b1;
                end else begin
                    win_cnt_d = win_cnt_q + BITS'(1);
                    if (w_sum >= w_period_len) begin
                        acc_d    = w_sum - w_period_len;
                        signal_d = ~signal_q;
                    end else begin
                        acc_d = w_sum;
                    end
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase

        if (w_boundary) begin
            win_cnt_d       = '0;
            acc_d           = '0;
            signal_d        = 1'b0;
            window_start_d  = 1'b1;
            update_period_d = w_commit_period;
            active_count_d  = w_decoded_count;
            load_pending_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= STATE_IDLE;
            win_cnt_q       <= '0;
            acc_q           <= '0;
            signal_q        <= 1'b0;
            window_start_q  <= 1'b0;
            load_pending_q  <= 1'b0;
            active_count_q  <= '0;
            update_period_q <= BITS'(UPDATE_PERIOD);
            pend_target_q   <= '0;
            pend_period_q   <= BITS'(UPDATE_PERIOD);
        end else begin
            state_q         <= state_d;
            win_cnt_q       <= win_cnt_d;
            acc_q           <= acc_d;
            signal_q        <= signal_d;
            window_start_q  <= window_start_d;
            load_pending_q  <= load_pending_d;
            active_count_q  <= active_count_d;
            update_period_q <= update_period_d;
            pend_target_q   <= pend_target_d;
            pend_period_q   <= pend_period_d;
        end
    end

    assign bus.signal       = signal_q;
    assign bus.window_start = window_start_q;
    assign bus.load_pending = load_pending_q;
    assign bus.active_count = active_count_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_signal_generator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_freq_signal_generator                                               |
// | Directed + random stimulus against a window/edge-count reference.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_freq_signal_generator;

    localparam int BITS = 12;
    localparam int UPD  = 1200;
    localparam int MAXC = 99;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    freq_signal_generator_if #(.BITS(BITS)) bus ();

    freq_signal_generator #(
        .BITS          (BITS),
        .UPDATE_PERIOD (UPD),
        .MAX_COUNT     (MAXC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: window position, committed length/count, pending loads.
    bit m_run, m_lp, m_fresh, first_seen;
    int m_pos, m_L, m_N, m_pt, m_pp, rises;
    logic e_sig, e_ws, prev_sig;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int decode(input int t);
        int v;
`ifdef FREQ_GEN_BCD_TARGET_EN
        int tens;
        int units;
        tens  = (t >> 4) & 15;
        units = t & 15;
        if (tens > 9)  tens = 9;
        if (units > 9) units = 9;
        v = tens * 10 + units;
`else
        v = t & 127;
`endif
        if (v > MAXC) v = MAXC;
        return v;
    endfunction

    function automatic int clamp_n(input int t, input int len);
        int v;
        v = decode(t);
        if (v > len / 2) v = len / 2;
        return v;
    endfunction

    task automatic tick();
        bit bnd;
        bnd = 1'b0;
        if (reset) begin
            m_run = 0; m_pos = 0; m_L = UPD + 1; m_N = 0; m_pt = 0; m_pp = UPD;
            m_lp = 0; e_sig = 0; e_ws = 0; m_fresh = 1; rises = 0; first_seen = 0;
        end else begin
            if (bus.target_load) m_pt = int'(bus.target);
            if (bus.period_load) m_pp = int'(bus.period);
            if (bus.target_load || bus.period_load) m_lp = 1;
            e_ws = 0;
            if (!m_run) begin
                if (bus.enable) bnd = 1;
            end else if (!bus.enable) begin
                m_run = 0; m_pos = 0; e_sig = 0; rises = 0;
            end else if (m_pos == m_L - 1) begin
                chk("edges_per_window", rises, m_N);
                bnd = 1;
            end else begin
                m_pos++;
                // Toggles so far in this window = floor(pos*2N/L).
                e_sig = logic'(((m_pos * 2 * m_N) / m_L) % 2);
            end
            if (bnd) begin
                m_run = 1; m_pos = 0; m_L = m_pp + 1; m_N = clamp_n(m_pt, m_L);
                m_lp = 0; e_ws = 1; e_sig = 0; m_fresh = 0; rises = 0; first_seen = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("signal", 32'(bus.signal), 32'(e_sig));
        chk("window_start", 32'(bus.window_start), 32'(e_ws));
        chk("load_pending", 32'(bus.load_pending), 32'(m_lp));
        if (m_run || m_fresh) chk("active_count", 32'(bus.active_count), m_N);
        if (bus.signal === 1'b1 && prev_sig === 1'b0) begin
            rises++;
            if (!first_seen && m_run && m_N > 0) begin
                chk("first_edge_latency", m_pos, (m_L + 2 * m_N - 1) / (2 * m_N));
                first_seen = 1;
            end
        end
        prev_sig = bus.signal;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to_last(input int limit);
        int k;
        k = 0;
        while (!(m_run && m_pos == m_L - 1) && k < limit) begin tick(); k++; end
        if (k >= limit) begin
            checks++; errors++;
            $error("FAIL wait_boundary: observed timeout expected boundary within %0d", limit);
        end
    endtask

    task automatic run_to_pos(input int p, input int limit);
        int k;
        k = 0;
        while (!(m_run && m_pos == p) && k < limit) begin tick(); k++; end
        if (k >= limit) begin
            checks++; errors++;
            $error("FAIL wait_pos: observed timeout expected pos %0d", p);
        end
    endtask

    task automatic run_to_high(input int limit);
        int k;
        k = 0;
        while (!(m_run && e_sig === 1'b1) && k < limit) begin tick(); k++; end
        if (k >= limit) begin
            checks++; errors++;
            $error("FAIL wait_high: observed timeout expected signal high");
        end
    endtask

    task automatic load_target(input logic [7:0] t);
        bus.target = t; bus.target_load = 1'b1; tick(); bus.target_load = 1'b0;
    endtask

    task automatic load_period(input logic [BITS-1:0] p);
        bus.period = p; bus.period_load = 1'b1; tick(); bus.period_load = 1'b0;
    endtask

    initial begin
        prev_sig = 1'b0;
        reset = 1'b1;
        bus.enable = 1'b0; bus.target = '0; bus.target_load = 1'b0;
        bus.period = '0; bus.period_load = 1'b0;
        run(2);
        reset = 1'b0;

        // L=10, N=3, then clamp of 10 to L>>1=5 (toggle every clock)
        bus.period = BITS'(9); bus.period_load = 1'b1;
        bus.target = 8'd3; bus.target_load = 1'b1;
        tick();
        bus.period_load = 1'b0; bus.target_load = 1'b0;
        run(2);
        bus.enable = 1'b1;
        run(45);
        load_target(8'd10);
        run(25);

        // Mid-window load, then a load on the boundary cycle itself
        run_to_pos(4, 50);
        load_target(8'd2);
        run(25);
        run_to_last(50);
        load_target(8'd4);
        run(25);

        // Abort while high, then reset while high
        run_to_high(50);
        bus.enable = 1'b0;
        run(3);
        bus.enable = 1'b1;
        run(22);
        run_to_high(50);
        reset = 1'b1;
        bus.enable = 1'b0;
        tick();
        reset = 1'b0;

        // Default period (L=1201): 50, then 120 (clamps to 99), then 0
        load_target(8'd50);
        bus.enable = 1'b1;
        run(3 * 1201 + 5);
        load_target(8'd120);
        run_to_last(1300);
        run(2 * 1201 + 2);
        load_target(8'd0);
        run_to_last(1300);
        run(2 * 1201 + 2);

        // L=1: window_start every clock, signal held low
        load_period(BITS'(0));
        run_to_last(1300);
        run(12);

`ifdef FREQ_GEN_BCD_TARGET_EN
        bus.period = BITS'(UPD); bus.period_load = 1'b1;
        bus.target = 8'h42; bus.target_load = 1'b1;
        tick();
        bus.period_load = 1'b0; bus.target_load = 1'b0;
        run(2 * 1201 + 4);
        load_target(8'hAF);
        run_to_last(1300);
        run(2 * 1201 + 2);
`endif

        // Randomised loads, enable drops and resets over short windows
        load_period(BITS'(12));
        for (int i = 0; i < 4000; i++) begin
            bus.target_load = ($urandom_range(0, 29) == 0);
            if (bus.target_load) bus.target = 8'($urandom);
            bus.period_load = ($urandom_range(0, 39) == 0);
            if (bus.period_load) bus.period = BITS'($urandom_range(0, 30));
            bus.enable = ($urandom_range(0, 199) != 0);
            reset = ($urandom_range(0, 799) == 0);
            tick();
        end
        reset = 1'b0; bus.target_load = 1'b0; bus.period_load = 1'b0;
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
